// File: rtl/divider_scheduler.sv
// divider_scheduler: round-robin sharing of one repeated-subtraction divider between NREQ requesters,
// with local divide-by-zero trapping and a watchdog on every divide.
module divider_scheduler #(
  parameter int SIZE = 10,
  parameter int NREQ = 2,
  parameter int TIMEOUT = 1040,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] req_num,
  input  logic [NREQ*SIZE-1:0] req_den,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [SIZE-1:0]      rsp_quotient,
  output logic [SIZE-1:0]      rsp_remainder,
  output logic                 rsp_error,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 div_clear,
  output logic                 div_start,
  output logic [SIZE-1:0]      div_numerator,
  output logic [SIZE-1:0]      div_denominator,
  input  logic [SIZE-1:0]      div_quotient,
  input  logic [SIZE-1:0]      div_remainder,
  input  logic                 div_done
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, SETTLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, grant_q, grant_d, pick;
  logic [SIZE-1:0] num_q, num_d, den_q, den_d, quo_q, quo_d, rem_q, rem_d;
  logic [NREQ-1:0] valid_q, valid_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic err_q, err_d, busy_q, busy_d, clear_q, clear_d, start_q, start_d, found;
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick = IDW'(idx);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    num_d = num_q;
    den_d = den_q;
    quo_d = quo_q;
    rem_d = rem_q;
    err_d = err_q;
    wd_d = wd_q;
    clear_d = 1'b0;
    start_d = 1'b0;
    valid_d = '0;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        num_d = req_num[int'(pick)*SIZE +: SIZE];
        den_d = req_den[int'(pick)*SIZE +: SIZE];
        if (den_d == '0) begin
          quo_d = '1;
          rem_d = num_d;
          err_d = 1'b1;
          state_d = RESP;
        end else begin
          clear_d = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = SETTLE;
      SETTLE: begin
        wd_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (div_done || wd_q == WDW'(TIMEOUT - 1)) begin
          quo_d = div_quotient;
          rem_d = div_remainder;
          err_d = !div_done;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RESP) valid_d[grant_d] = 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= IDW'(NREQ - 1);
      grant_q <= '0;
      num_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
      wd_q <= '0;
      clear_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      num_q <= num_d;
      den_q <= den_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      err_q <= err_d;
      wd_q <= wd_d;
      clear_q <= clear_d;
      start_q <= start_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end
  assign rsp_valid = valid_q;
  assign rsp_quotient = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_error = err_q;
  assign busy = busy_q;
  assign grant_id = grant_q;
  assign div_clear = clear_q;
  assign div_start = start_q;
  assign div_numerator = num_q;
  assign div_denominator = den_q;
endmodule

// File: doc/divider_scheduler.md
Name: divider_scheduler

Overview:
Shares one repeated-subtraction integer divider instance between NREQ requesters (e.g. keypad operation unit, display BCD converter). Arbitration is round-robin. The scheduler sequences clear/start/done on the divider and returns quotient/remainder to the winning requester. Zero denominators are trapped locally, because the divider never terminates on d=0. A watchdog bounds every divide.

Parameters:
SIZE, 10, operand/result width; must match divider SIZE
NREQ, 2, number of requesters (2..8)
TIMEOUT, 1040, max cycles in WAIT before error abort (must be >= 2**SIZE+4)
IDW (localparam), max(1,$clog2(NREQ)), requester index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level; held high, operands stable, until matching rsp_valid
req_num  in  NREQ*SIZE  packed numerators, requester i at [i*SIZE +: SIZE]
req_den  in  NREQ*SIZE  packed denominators, same packing
rsp_valid  out  NREQ  one-hot, single-cycle response strobe to winner
rsp_quotient  out  SIZE  result quotient, valid when any rsp_valid bit is high
rsp_remainder  out  SIZE  result remainder, valid with rsp_valid
rsp_error  out  1  1 = divide-by-zero or timeout, valid with rsp_valid
busy  out  1  high in every state except IDLE
grant_id  out  IDW  index of the current/last winner
div_clear  out  1  drives divider reset; one-cycle pulse
div_start  out  1  divider start; one-cycle pulse
div_numerator  out  SIZE  latched numerator of the winner
div_denominator  out  SIZE  latched denominator of the winner
div_quotient  in  SIZE  divider quotient
div_remainder  in  SIZE  divider remainder
div_done  in  1  divider completion level

Behaviour:
- Reset (async): state=IDLE, all outputs 0, round-robin pointer = NREQ-1, so requester 0 has first priority.
- States: IDLE, CLEAR, ISSUE, SETTLE, WAIT, RESP.
- IDLE: if any req bit is set, pick the first set bit searching from pointer+1 upward with wrap. Latch its operands into div_numerator/div_denominator, set grant_id.
  - den==0: go to RESP with rsp_quotient = all ones, rsp_remainder = num, rsp_error = 1.
  - otherwise: go to CLEAR.
- CLEAR: div_clear=1 for exactly one cycle, so the divider quotient starts from 0. Go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle; div_clear=0. Go to SETTLE.
- SETTLE: one cycle. Ignore div_done (it may be stale from the prior op). Clear the watchdog. Go to WAIT.
- WAIT: increment watchdog each cycle.
  - div_done=1: capture div_quotient/div_remainder, rsp_error=0, go to RESP.
  - watchdog == TIMEOUT-1 without done: rsp_error=1, quotient/remainder = divider values at that cycle, go to RESP.
- RESP: rsp_valid[grant_id]=1 for one cycle. Pointer <= grant_id. Go to IDLE.
- Result hold: rsp_* data holds until the next RESP.
- Latency: the request is accepted on edge E0. For den!=0 and quotient Q, rsp_valid is high in the cycle after edge E0+Q+4. For den==0, rsp_valid is high in the cycle after E0.
- Request release: a requester must drop req in the cycle after rsp_valid. If req is still high in IDLE, it counts as a new request, but it competes behind others because the pointer has advanced.
- Mid-operation changes: req deasserted during an operation is ignored; the op completes and the response is still strobed. Operand changes during an operation are ignored (operands were latched in IDLE).
- Simultaneous requests: exactly one grant per IDLE cycle. No requester waits more than NREQ-1 other operations.
- Reset mid-operation: return to IDLE immediately. No rsp_valid is issued. The divider is cleared on the next grant.

Test Plan:
- Single op: req[0], num=100, den=7 -> rsp_valid[0] one cycle, quotient=14, remainder=2, error=0; rsp_valid 18 cycles after acceptance (Q+4).
- Zero denominator: req[1], num=55, den=0 -> div_start never pulses; rsp_valid[1] next cycle, quotient=1023, remainder=55, error=1.
- Back-to-back stale quotient: 20/3 then 9/4 on requester 0 -> second result is quotient=2, remainder=1 (not accumulated 8).
- Contention: req=2'b11 held, four ops -> grants alternate 0,1,0,1; after reset the first grant is 0.
- Timeout: divider model never raises done, TIMEOUT=16 -> rsp_valid after WAIT count 16, error=1, busy falls next cycle.
- Reset mid-WAIT: assert reset during WAIT -> busy=0, no rsp_valid; a subsequent 9/3 returns quotient 3, remainder 0.
